// File: rtl/snn_interfaces_pkg.sv
// Shared types and sizing for the SNN convolution datapath.
// Holds the event bundle, kernel address type and address helper.
package snn_interfaces_pkg;

    localparam int IN_CHANNELS        = 2;
    localparam int OUT_CHANNELS       = 2;
    localparam int KERNEL_SIZE        = 3;
    localparam int KERNEL_WEIGHT_BITS = 6;
    localparam int IMG_WIDTH          = 32;
    localparam int IMG_HEIGHT         = 32;
    localparam int COORD_BITS         = 8;
    localparam int TIMESTEP_BITS      = 16;

    localparam int CH_BITS    = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
    localparam int K_BITS     = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int KADDR_BITS = $clog2(IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE);
    localparam int WVEC_BITS  = OUT_CHANNELS * KERNEL_WEIGHT_BITS;

    typedef struct packed {
        logic [TIMESTEP_BITS-1:0] timestep;
        logic [COORD_BITS-1:0]    x;
        logic [COORD_BITS-1:0]    y;
        logic [IN_CHANNELS-1:0]   spikes;
    } output_vector_t;

    typedef logic [KADDR_BITS-1:0] kernel_addr_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } sched_state_t;

    function automatic kernel_addr_t kernel_addr(
        input int ch,
        input int ky,
        input int kx,
        input int k
    );
        return kernel_addr_t'(ch * k * k + ky * k + kx);
    endfunction

endpackage

// File: rtl/conv_kernel_scheduler_picker.sv
// Finds the lowest set spike bit, either from bit 0 or strictly
// above the current channel; flags when no channel remains.
module spike_channel_picker
    import snn_interfaces_pkg::*;
(
    input  logic [IN_CHANNELS-1:0] mask,
    input  logic [CH_BITS-1:0]     cur_ch,
    input  logic                   from_start,
    output logic [CH_BITS-1:0]     next_ch,
    output logic                   none_left
);

    always_comb begin
        next_ch   = '0;
        none_left = 1'b1;
        // Descending scan so the lowest qualifying bit wins.
        for (int i = IN_CHANNELS - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || (i > int'(cur_ch)))) begin
                next_ch   = CH_BITS'(i);
                none_left = 1'b0;
            end
        end
    end

endmodule

// File: rtl/conv_kernel_scheduler.sv
// Walks active channels and kernel taps of one spike event,
// issues weight BRAM reads and forwards tagged weight vectors.
module conv_kernel_scheduler
    import snn_interfaces_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   event_valid,
    output logic                   event_ready,
    input  output_vector_t         event_in,
    output logic                   bram_en,
    output logic [KADDR_BITS-1:0]  bram_addr,
    input  logic [WVEC_BITS-1:0]   bram_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COORD_BITS-1:0]  out_x,
    output logic [COORD_BITS-1:0]  out_y,
    output logic [CH_BITS-1:0]     out_ch,
    output logic [WVEC_BITS-1:0]   out_weights,
    output logic                   busy,
    output logic                   done
);

    localparam int TW   = COORD_BITS + 1;
    localparam int HALF = KERNEL_SIZE / 2;
    localparam logic [K_BITS-1:0] K_LAST = K_BITS'(KERNEL_SIZE - 1);

    sched_state_t          state_q, state_d;
    output_vector_t        ev_q, ev_d;
    logic [CH_BITS-1:0]    ch_q, ch_d;
    logic [K_BITS-1:0]     kx_q, kx_d;
    logic [K_BITS-1:0]     ky_q, ky_d;
    logic                  out_valid_q, out_valid_d;
    logic [COORD_BITS-1:0] out_x_q, out_x_d;
    logic [COORD_BITS-1:0] out_y_q, out_y_d;
    logic [CH_BITS-1:0]    out_ch_q, out_ch_d;
    logic                  zero_done_q, zero_done_d;

    logic                   pick_start;
    logic [IN_CHANNELS-1:0] pick_mask;
    logic [CH_BITS-1:0]     pick_ch;
    logic                   pick_none;

    logic signed [TW-1:0] tx, ty;
    logic                 in_bounds, stall, fire, advance, drain_done;
    logic                 unused_timestep;

    assign pick_start = (state_q == S_IDLE);
    assign pick_mask  = pick_start ? event_in.spikes : ev_q.spikes;

    spike_channel_picker u_picker (
        .mask       (pick_mask),
        .cur_ch     (ch_q),
        .from_start (pick_start),
        .next_ch    (pick_ch),
        .none_left  (pick_none)
    );

    // Output neuron fed by this tap; kept signed to catch left/top overrun.
    always_comb begin
        tx = $signed({1'b0, ev_q.x}) - $signed(TW'(kx_q)) + $signed(TW'(HALF));
        ty = $signed({1'b0, ev_q.y}) - $signed(TW'(ky_q)) + $signed(TW'(HALF));
        in_bounds = !tx[TW-1] && !ty[TW-1]
                 && (tx < $signed(TW'(IMG_WIDTH)))
                 && (ty < $signed(TW'(IMG_HEIGHT)));
    end

    assign stall      = out_valid_q && !out_ready;
    assign fire       = (state_q == S_ISSUE) && in_bounds && !stall;
    assign advance    = (state_q == S_ISSUE) && (!in_bounds || !stall);
    assign drain_done = (state_q == S_DRAIN) && (!out_valid_q || out_ready);

    always_comb begin
        state_d     = state_q;
        ev_d        = ev_q;
        ch_d        = ch_q;
        kx_d        = kx_q;
        ky_d        = ky_q;
        zero_done_d = 1'b0;
        out_valid_d = fire || stall;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_ch_d    = out_ch_q;
        if (fire) begin
            out_x_d  = tx[COORD_BITS-1:0];
            out_y_d  = ty[COORD_BITS-1:0];
            out_ch_d = ch_q;
        end
        unique case (state_q)
            S_IDLE: begin
                if (event_valid) begin
                    ev_d = event_in;
                    ch_d = pick_ch;
                    kx_d = '0;
                    ky_d = '0;
                    if (pick_none) zero_done_d = 1'b1;
                    else           state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (advance) begin
                    if (kx_q != K_LAST) begin
                        kx_d = kx_q + K_BITS'(1);
                    end else begin
                        kx_d = '0;
                        if (ky_q != K_LAST) begin
                            ky_d = ky_q + K_BITS'(1);
                        end else begin
                            ky_d = '0;
                            if (pick_none) state_d = S_DRAIN;
                            else           ch_d    = pick_ch;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (drain_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ev_q        <= '0;
            ch_q        <= '0;
            kx_q        <= '0;
            ky_q        <= '0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_ch_q    <= '0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ev_q        <= ev_d;
            ch_q        <= ch_d;
            kx_q        <= kx_d;
            ky_q        <= ky_d;
            out_valid_q <= out_valid_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_ch_q    <= out_ch_d;
            zero_done_q <= zero_done_d;
        end
    end

    assign unused_timestep = ^ev_q.timestep;

    assign event_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign done        = zero_done_q || drain_done;
    assign bram_en     = fire;
    assign bram_addr   = fire ? kernel_addr(int'(ch_q), int'(ky_q), int'(kx_q),
                                            KERNEL_SIZE)
                              : '0;
    assign out_valid   = out_valid_q;
    assign out_x       = out_x_q;
    assign out_y       = out_y_q;
    assign out_ch      = out_ch_q;
    assign out_weights = out_valid_q ? bram_rdata : '0;

endmodule

// File: tb/tb_conv_kernel_scheduler.sv
// Bench for conv_kernel_scheduler: directed scenarios plus random
// events checked against a tap-list model and a BRAM model.
module tb_conv_kernel_scheduler;
    import snn_interfaces_pkg::*;

    typedef struct {
        int addr;
        int x;
        int y;
        int ch;
    } tap_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  event_valid = 1'b0;
    logic                  event_ready;
    output_vector_t        event_in = '0;
    logic                  bram_en;
    logic [KADDR_BITS-1:0] bram_addr;
    logic [WVEC_BITS-1:0]  bram_rdata = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [COORD_BITS-1:0] out_x, out_y;
    logic [CH_BITS-1:0]    out_ch;
    logic [WVEC_BITS-1:0]  out_weights;
    logic                  busy, done;

    int   n_checks = 0;
    int   n_fail = 0;
    tap_t exp_q[$];

    always #5 clk = ~clk;

    conv_kernel_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .event_valid (event_valid),
        .event_ready (event_ready),
        .event_in    (event_in),
        .bram_en     (bram_en),
        .bram_addr   (bram_addr),
        .bram_rdata  (bram_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_ch      (out_ch),
        .out_weights (out_weights),
        .busy        (busy),
        .done        (done)
    );

    function automatic logic [WVEC_BITS-1:0] wgt(input int a);
        logic [KERNEL_WEIGHT_BITS-1:0] hi, lo;
        hi = KERNEL_WEIGHT_BITS'(a * 5 + 3);
        lo = KERNEL_WEIGHT_BITS'(a ^ 21);
        return WVEC_BITS'({hi, lo});
    endfunction

    // Weight memory: one-cycle read, holds data while not enabled.
    always @(posedge clk) begin
        if (bram_en) bram_rdata <= wgt(int'(bram_addr));
    end

    function automatic output_vector_t mk_ev(input int ts, input int x,
                                             input int y,
                                             input logic [IN_CHANNELS-1:0] sp);
        output_vector_t e;
        e.timestep = TIMESTEP_BITS'(ts);
        e.x        = COORD_BITS'(x);
        e.y        = COORD_BITS'(y);
        e.spikes   = sp;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic build_expect(input output_vector_t ev);
        int tx, ty;
        exp_q.delete();
        for (int ch = 0; ch < IN_CHANNELS; ch++) begin
            if (ev.spikes[ch]) begin
                for (int ky = 0; ky < KERNEL_SIZE; ky++) begin
                    for (int kx = 0; kx < KERNEL_SIZE; kx++) begin
                        tx = int'(ev.x) - kx + KERNEL_SIZE / 2;
                        ty = int'(ev.y) - ky + KERNEL_SIZE / 2;
                        if (tx >= 0 && tx < IMG_WIDTH && ty >= 0 && ty < IMG_HEIGHT)
                            exp_q.push_back('{ch * KERNEL_SIZE * KERNEL_SIZE
                                              + ky * KERNEL_SIZE + kx,
                                              tx, ty, ch});
                    end
                end
            end
        end
    endtask

    task automatic run_event(input output_vector_t ev, input int mode,
                             input bit keep_valid, input int abort_after,
                             output int done_cyc, output int n_rd,
                             output tap_t first_o, output tap_t last_o);
        tap_t rd_q[$];
        tap_t o_q[$];
        int   cyc, nch, stall_left, n_out;
        bit   done_seen, prev_en, prev_ov, prev_rdy;
        logic [COORD_BITS-1:0] hx, hy;
        logic [CH_BITS-1:0]    hc;
        logic [WVEC_BITS-1:0]  hw;
        build_expect(ev);
        rd_q = exp_q;
        o_q  = exp_q;
        nch  = $countones(ev.spikes);
        cyc = 0; stall_left = 3; n_out = 0; n_rd = 0; done_cyc = -1;
        done_seen = 0; prev_en = 0; prev_ov = 0; prev_rdy = 1;
        hx = '0; hy = '0; hc = '0; hw = '0;
        first_o = '{-1, -1, -1, -1};
        last_o  = '{-1, -1, -1, -1};
        @(negedge clk);
        event_in    = ev;
        event_valid = 1'b1;
        out_ready   = 1'b1;
        #1 chk("accept_ready", event_ready, 1);
        @(posedge clk);
        while (!done_seen && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (!keep_valid) event_valid = 1'b0;
            case (mode)
                1: begin
                    if (n_out == 1 && stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                2: out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = 1'b1;
            endcase
            #1;
            chk("out_valid_timing", out_valid, prev_en | (prev_ov & !prev_rdy));
            chk("busy", busy, nch > 0);
            if (keep_valid) chk("ready_while_busy", event_ready, nch == 0);
            if (prev_ov && !prev_rdy) begin
                chk("hold_x", out_x, hx);
                chk("hold_y", out_y, hy);
                chk("hold_ch", out_ch, hc);
                chk("hold_w", out_weights, hw);
            end
            if (out_valid && !out_ready) chk("stall_no_read", bram_en, 0);
            if (bram_en) begin
                n_rd++;
                if (rd_q.size() == 0) begin
                    chk("extra_read", bram_en, 0);
                end else begin
                    chk("read_addr", bram_addr, rd_q[0].addr);
                    void'(rd_q.pop_front());
                end
            end
            if (out_valid && out_ready) begin
                if (o_q.size() == 0) begin
                    chk("extra_out", out_valid, 0);
                end else begin
                    chk("out_x", out_x, o_q[0].x);
                    chk("out_y", out_y, o_q[0].y);
                    chk("out_ch", out_ch, o_q[0].ch);
                    chk("out_w", out_weights, wgt(o_q[0].addr));
                    void'(o_q.pop_front());
                end
                if (n_out == 0)
                    first_o = '{-1, int'(out_x), int'(out_y), int'(out_ch)};
                last_o = '{-1, int'(out_x), int'(out_y), int'(out_ch)};
                n_out++;
            end
            if (done) begin
                done_seen = 1;
                done_cyc  = cyc;
                chk("reads_all_seen", rd_q.size(), 0);
                chk("outs_all_seen", o_q.size(), 0);
            end
            if (abort_after > 0 && n_rd >= abort_after) break;
            prev_en  = bram_en;
            prev_ov  = out_valid;
            prev_rdy = out_ready;
            hx = out_x; hy = out_y; hc = out_ch; hw = out_weights;
        end
        if (!done_seen && abort_after == 0) chk("done_timeout", 0, 1);
        if (mode == 0 && abort_after == 0)
            chk("done_cycle", done_cyc,
                (nch == 0) ? 1 : nch * KERNEL_SIZE * KERNEL_SIZE + 1);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_ready"}, event_ready, 1);
        chk({tag, "_bram_en"}, bram_en, 0);
        chk({tag, "_bram_addr"}, bram_addr, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_xy"}, {out_x, out_y}, 0);
        chk({tag, "_out_ch"}, out_ch, 0);
        chk({tag, "_out_w"}, out_weights, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        output_vector_t ev1, ev;
        int   dc, nr, rx, ry, md;
        tap_t f, l;
        ev1 = mk_ev(1, 5, 3, 2'b11);

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 chk_idle_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_event(ev1, 0, 0, 0, dc, nr, f, l);
        chk("s1_reads", nr, 18);
        chk("s1_done", dc, 19);
        chk("s1_first", {f.x, f.y, f.ch}, {32'd6, 32'd4, 32'd0});
        chk("s1_last", {l.x, l.y, l.ch}, {32'd4, 32'd2, 32'd1});

        run_event(mk_ev(2, 0, 0, 2'b01), 0, 0, 0, dc, nr, f, l);
        chk("s2_reads", nr, 4);
        chk("s2_done", dc, 10);
        chk("s2_first", {f.x, f.y, f.ch}, {32'd1, 32'd1, 32'd0});
        chk("s2_last", {l.x, l.y, l.ch}, {32'd0, 32'd0, 32'd0});

        run_event(mk_ev(3, 7, 7, 2'b00), 0, 0, 0, dc, nr, f, l);
        chk("s3_reads", nr, 0);
        chk("s3_done", dc, 1);

        run_event(ev1, 1, 0, 0, dc, nr, f, l);
        chk("s4_reads", nr, 18);
        chk("s4_done", dc, 22);

        run_event(ev1, 0, 1, 0, dc, nr, f, l);
        chk("s5_done_a", dc, 19);
        run_event(mk_ev(5, 10, 10, 2'b10), 0, 0, 0, dc, nr, f, l);
        chk("s5_done_b", dc, 10);
        chk("s5_reads_b", nr, 9);

        run_event(ev1, 0, 0, 5, dc, nr, f, l);
        chk("s6_reads_before_reset", nr, 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk_idle_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        run_event(ev1, 0, 0, 0, dc, nr, f, l);
        chk("s6_reads_after", nr, 18);

        for (int i = 0; i < 24; i++) begin
            rx = ($urandom_range(0, 3) == 0) ? 31 * $urandom_range(0, 1)
                                             : $urandom_range(0, 31);
            ry = ($urandom_range(0, 3) == 0) ? 31 * $urandom_range(0, 1)
                                             : $urandom_range(0, 31);
            ev = mk_ev(100 + i, rx, ry, IN_CHANNELS'($urandom_range(0, 3)));
            md = 2 * $urandom_range(0, 1);
            run_event(ev, md, 0, 0, dc, nr, f, l);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
